// File: rtl/tiny_proc_pkg.sv
// Shared constants for the tiny processor: program memory geometry, loader
// state encoding and the power-on LED program.
package tiny_proc_pkg;

  localparam int MEM_DEPTH = 16;
  localparam int ADDR_W    = 4;
  localparam int WORD_W    = 8;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } load_state_e;

  // LED walking pattern, then a jump back; unused words are zero.
  function automatic logic [WORD_W-1:0] default_word(input logic [ADDR_W-1:0] a);
    logic [WORD_W-1:0] w;
    case (a)
      4'd0:    w = 8'h81;
      4'd1:    w = 8'h82;
      4'd2:    w = 8'h84;
      4'd3:    w = 8'h88;
      4'd4:    w = 8'h84;
      4'd5:    w = 8'h82;
      4'd6:    w = 8'hA0;
      default: w = 8'h00;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/tiny_prog_ram.sv
// 16x8 program store: one synchronous write port, one asynchronous read port,
// reset restores the default program.
module tiny_prog_ram
  import tiny_proc_pkg::*;
(
  input  logic              clock,
  input  logic              reset_p,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clock or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= default_word(ADDR_W'(i));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tiny_prog_loader.sv
// Byte-stream program loader for the tiny processor; holds the CPU in reset
// while downloading. Optional trailing checksum byte: TINY_PROG_LOADER_CHECKSUM_EN.
module tiny_prog_loader
  import tiny_proc_pkg::*;
(
  input  logic              clock,
  input  logic              reset_p,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [WORD_W-1:0] fetch_data,
  output logic              cpu_reset_p,
  output logic              load_done,
  output logic              load_err
);

  load_state_e       state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [WORD_W-1:0] sum, sum_nxt;
  logic [WORD_W-1:0] sum_with_byte;
  logic              accept;
  logic              wr_en;

  // Handshake: a byte moves when in_valid && in_ready at the rising edge;
  // in_ready depends only on state, and a coincident load_start voids the byte.
  assign in_ready      = (state == ST_LOAD) || (state == ST_CHECK);
  assign accept        = in_valid && in_ready && !load_start;
  assign sum_with_byte = sum + in_data;

  always_ff @(posedge clock or posedge reset_p) begin
    if (reset_p) begin
      state <= ST_IDLE;
      addr  <= '0;
      sum   <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      sum   <= sum_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    sum_nxt   = sum;
    wr_en     = 1'b0;
    if (load_start) begin
      state_nxt = ST_LOAD;
      addr_nxt  = '0;
      sum_nxt   = '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            wr_en    = 1'b1;
            addr_nxt = addr + 1'b1;
            sum_nxt  = sum_with_byte;
            if (addr == LAST_ADDR) begin
`ifdef TINY_PROG_LOADER_CHECKSUM_EN
              state_nxt = ST_CHECK;
`else
              state_nxt = ST_DONE;
`endif
            end
          end
        end
        ST_CHECK: begin
          if (accept) begin
            state_nxt = (sum_with_byte == '0) ? ST_DONE : ST_ERR;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_reset_p = (state == ST_LOAD) || (state == ST_CHECK) || (state == ST_ERR);
  assign load_done   = (state == ST_DONE);
`ifdef TINY_PROG_LOADER_CHECKSUM_EN
  assign load_err    = (state == ST_ERR);
`else
  assign load_err    = 1'b0;
`endif

  tiny_prog_ram u_ram (
    .clock   (clock),
    .reset_p (reset_p),
    .we      (wr_en),
    .waddr   (addr),
    .wdata   (in_data),
    .raddr   (fetch_addr),
    .rdata   (fetch_data)
  );

endmodule

// File: tb/tb_tiny_prog_loader.sv
// Bench for tiny_prog_loader: behavioural download model checked every cycle,
// plus directed literal checks; follows TINY_PROG_LOADER_CHECKSUM_EN.
module tb_tiny_prog_loader;

  logic       clock = 1'b0;
  logic       reset_p = 1'b0;
  logic       load_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [3:0] fetch_addr = 4'h0;
  logic [7:0] fetch_data;
  logic       cpu_reset_p;
  logic       load_done;
  logic       load_err;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Model: memory image, whether a download is in progress, bytes taken so far,
  // running sum, and the sticky outcome of the last download.
  logic [7:0] model_mem [16];
  bit         m_busy, m_done, m_err;
  int         m_n, m_sum;
  logic [7:0] exp_q [$];

`ifdef TINY_PROG_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  tiny_prog_loader dut (
    .clock       (clock),
    .reset_p     (reset_p),
    .load_start  (load_start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .fetch_addr  (fetch_addr),
    .fetch_data  (fetch_data),
    .cpu_reset_p (cpu_reset_p),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] default_prog(input int a);
    logic [7:0] tbl [7];
    tbl = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h84, 8'h82, 8'hA0};
    return (a < 7) ? tbl[a] : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  always @(posedge clock or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < 16; i++) model_mem[i] = default_prog(i);
      m_busy = 0; m_done = 0; m_err = 0; m_n = 0; m_sum = 0;
    end else if (load_start) begin
      m_busy = 1; m_done = 0; m_err = 0; m_n = 0; m_sum = 0;
    end else if (m_busy && in_valid) begin
      if (m_n < 16) begin
        model_mem[m_n] = in_data;
        m_sum = (m_sum + in_data) % 256;
        m_n++;
        if (m_n == 16 && !CK) begin
          m_busy = 0; m_done = 1;
        end
      end else begin
        m_busy = 0;
        if ((m_sum + in_data) % 256 == 0) m_done = 1;
        else m_err = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("fetch_data", fetch_data, model_mem[fetch_addr]);
      chk("in_ready", in_ready, m_busy);
      chk("cpu_reset_p", cpu_reset_p, m_busy || m_err);
      chk("load_done", load_done, m_done);
      chk("load_err", load_err, m_err);
    end
  end

  // ---------------- driver tasks (start/end at posedge+1) ----------------
  task automatic pulse_start(input bit with_byte);
    load_start = 1'b1;
    in_valid   = with_byte;
    in_data    = 8'($urandom);
    @(posedge clock); #1;
    load_start = 1'b0;
    in_valid   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gappy);
    bit sent = 0;
    bit accepted;
    int budget = 0;
    while (!sent && budget < 64) begin
      in_valid   = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data    = in_valid ? b : 8'($urandom);
      fetch_addr = 4'($urandom);
      accepted   = in_valid && in_ready;
      @(posedge clock); #1;
      sent = accepted;
      budget++;
    end
    in_valid = 1'b0;
    if (!sent) chk("send_timeout", 0, 1);
  endtask

  task automatic idle_noise(input int n);
    repeat (n) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_data    = 8'($urandom);
      fetch_addr = 4'($urandom);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic peek(input int a, input logic [7:0] exp, input string name);
    fetch_addr = 4'(a);
    @(posedge clock); #1;
    chk(name, fetch_data, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nb, s;
    logic [7:0] b, ck;

    #2 reset_p = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    reset_p = 1'b0;
    cmp_en  = 1'b1;

    // reset state and default program
    chk("rst_cpu_reset", cpu_reset_p, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    for (int a = 0; a < 7; a++) peek(a, default_prog(a), "rst_mem");
    peek(0, 8'h81, "rst_mem0");
    peek(6, 8'hA0, "rst_mem6");
    idle_noise(4);
    chk("idle_no_start", cpu_reset_p, 0);

    // bytes 01..10, sum 0x88
    pulse_start(0);
    for (int i = 1; i <= 16; i++) send_byte(8'(i), 0);
`ifdef TINY_PROG_LOADER_CHECKSUM_EN
    send_byte(8'h78, 0);
`endif
    chk("good_done", load_done, 1);
    chk("good_cpu_reset", cpu_reset_p, 0);
    chk("good_err", load_err, 0);
    idle_noise(4);
    chk("done_in_ready", in_ready, 0);
    peek(15, 8'h10, "good_mem15");
    peek(0, 8'h01, "good_mem0");

`ifdef TINY_PROG_LOADER_CHECKSUM_EN
    // same stream, wrong checksum
    pulse_start(0);
    for (int i = 1; i <= 16; i++) send_byte(8'(i), 0);
    send_byte(8'h77, 0);
    chk("bad_err", load_err, 1);
    chk("bad_done", load_done, 0);
    chk("bad_cpu_reset", cpu_reset_p, 1);
    idle_noise(6);
    chk("bad_cpu_reset_held", cpu_reset_p, 1);
`endif

    // abort after 7 bytes; restart carries a coincident byte that must be dropped
    pulse_start(0);
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1);
    pulse_start(1);
    for (int i = 0; i < 16; i++) send_byte(8'hAF, 0);
`ifdef TINY_PROG_LOADER_CHECKSUM_EN
    send_byte(8'h10, 0);
`endif
    chk("af_done", load_done, 1);
    for (int a = 0; a < 16; a++) peek(a, 8'hAF, "af_mem");

    // in_valid toggled randomly during LOAD
    pulse_start(0);
    s = 0;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      s = (s + b) % 256;
      send_byte(b, 1);
    end
`ifdef TINY_PROG_LOADER_CHECKSUM_EN
    send_byte(8'((256 - s) % 256), 1);
`endif
    chk("gappy_done", load_done, 1);
    for (int a = 0; a < 16; a++) peek(a, exp_q.pop_front(), "gappy_mem");

    // random downloads: partial (restarted), correct or wrong checksum
    for (int r = 0; r < 8; r++) begin
      pulse_start(1'($urandom_range(0, 1)));
      nb = $urandom_range(3, 16);
      s = 0;
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        s = (s + b) % 256;
        send_byte(b, 1'($urandom_range(0, 1)));
      end
      if (CK && nb == 16) begin
        ck = $urandom_range(0, 1) ? 8'((256 - s) % 256) : 8'($urandom);
        send_byte(ck, 1);
      end
      idle_noise(3);
    end

    // reset in the middle of a download
    pulse_start(0);
    for (int i = 0; i < 5; i++) send_byte(8'h5A, 0);
    #2 reset_p = 1'b1;
    #1 reset_p = 1'b0;
    @(posedge clock); #1;
    chk("midrst_cpu_reset", cpu_reset_p, 0);
    chk("midrst_in_ready", in_ready, 0);
    for (int a = 0; a < 16; a++) peek(a, default_prog(a), "midrst_mem");

    idle_noise(2);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tiny_prog_loader.md
TINY_PROG_LOADER -- requirements
Module: tiny_prog_loader

Interface
REQ-001 SHALL have port clock  input  1  system clock; all state changes on the rising edge.
REQ-002 SHALL have port reset_p  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port load_start  input  1  one-cycle pulse that begins a program download.
REQ-004 SHALL have port in_valid  input  1  byte-stream valid.
REQ-005 SHALL have port in_data  input  8  byte-stream data, {INST[7:4], IMM[3:0]}.
REQ-006 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-007 SHALL have port fetch_addr  input  4  processor PC.
REQ-008 SHALL have port fetch_data  output  8  instruction word at fetch_addr.
REQ-009 SHALL have port cpu_reset_p  output  1  active-high hold-in-reset for the processor.
REQ-010 SHALL have port load_done  output  1  last download completed successfully (level).
REQ-011 SHALL have port load_err  output  1  last download failed its checksum (level).

Function
REQ-012 SHALL hold a 16x8 program memory, writable only by the byte stream.
REQ-013 SHALL drive fetch_data = mem[fetch_addr] combinationally, with zero-cycle read latency, in every state.
REQ-014 SHALL implement states IDLE, LOAD, CHECK, DONE, ERR.
REQ-015 SHALL transfer one byte on each cycle with in_valid && in_ready; in_valid without in_ready SHALL be ignored.
REQ-016 SHALL assert in_ready only in LOAD and CHECK.
REQ-017 SHALL, on load_start in any state, enter LOAD next cycle with write address=0 and running sum=0; a load_start during LOAD/CHECK restarts the download.
REQ-018 SHALL, in LOAD, write each accepted byte to mem[addr], add it to the 8-bit running sum (mod 256), and increment addr.
REQ-019 SHALL leave LOAD after the 16th accepted byte (addr 15): to CHECK with checksum enabled, else to DONE.
REQ-020 SHALL, in CHECK, accept one byte; if (sum + byte) mod 256 == 0, go to DONE, else go to ERR.
REQ-021 SHALL assert load_done only in DONE and load_err only in ERR; both SHALL appear the cycle after the terminating byte is accepted.
REQ-022 SHALL assert cpu_reset_p in LOAD, CHECK and ERR, and deassert it in IDLE and DONE.
REQ-023 SHALL remain in DONE, ERR or IDLE until load_start; in_valid in those states has no effect.
REQ-024 SHALL, when load_start and an accepted byte occur in the same cycle, discard the byte and apply the restart (load_start wins).
REQ-025 SHALL keep memory contents written before an aborted or failed download; no rollback.

Reset
REQ-026 SHALL, on reset_p, asynchronously enter IDLE with addr=0, sum=0, in_ready=0, cpu_reset_p=0, load_done=0, load_err=0.
REQ-027 SHALL reset the memory to the default program 81,82,84,88,84,82,A0 at addresses 0-6 and 00 at addresses 7-15, so the processor runs the LED pattern without a download.
REQ-028 SHALL, when reset occurs mid-download, abandon it completely; the memory holds the default program afterwards.

Configuration
REQ-029 SHALL honour macro TINY_PROG_LOADER_CHECKSUM_EN: when defined, the CHECK state and load_err are active; when undefined, LOAD goes directly to DONE, CHECK/ERR are unreachable, and load_err is tied to 0.

Structure
REQ-030 SHALL take the state encoding, memory depth (16), word width (8) and default-program constants from shared package tiny_proc_pkg.
REQ-031 SHALL place the storage in sub-module tiny_prog_ram (16x8, one synchronous write port, one asynchronous read port, reset-to-default).

Verification
REQ-032 SHALL verify reset only: fetch_addr 0..6 -> fetch_data 81,82,84,88,84,82,A0; cpu_reset_p=0.
REQ-033 SHALL verify checksum enabled: load_start, bytes 01..10 (sum 0x88), then checksum 0x78 -> load_done=1 the next cycle, cpu_reset_p=0, and mem[15]=0x10.
REQ-034 SHALL verify the same stream with checksum 0x77 -> load_err=1, and cpu_reset_p stays 1 until the next load_start.
REQ-035 SHALL verify in_valid toggled 50% randomly during LOAD -> exactly 16 bytes written in order with no duplicates.
REQ-036 SHALL verify load_start after byte 7, then a full 16-byte stream of 0xAF with checksum 0x10 -> load_done=1 and all memory locations 0xAF.
REQ-037 SHALL verify the checksum-disabled build: 16 bytes -> load_done the next cycle, and in_ready=0 thereafter.
